rf_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single register-file write port between three requesters: 0 = ALU result, 1 = load/memory result, 2 = link ($ra) write. It picks one requester per cycle and drives the 2-bit select of the 5-bit write-address mux and the 32-bit write-data mux. Its outputs are registered to form a write-back stage feeding the register file.

---
 rtl/rf_write_arbiter.sv | 91 +++++++++
 tb/tb_rf_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - round-robin arbiter for the single register-file write port
// Three requesters (ALU, load, link) share one write-back stage; outputs are registered.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        req_ready,
    input  logic              stall,
    output logic [1:0]        wr_sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    logic [1:0]        ptr;
    logic [1:0]        cand;
    logic [1:0]        gidx;
    logic              gvalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [1:0] next_idx(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Scan ptr, ptr+1, ptr+2 (mod 3); grants are suppressed in reset and under stall.
    always_comb begin
        gvalid = 1'b0;
        gidx   = 2'd0;
        cand   = ptr;
        if (rst_n && !stall) begin
            for (int k = 0; k < 3; k++) begin
                if (!gvalid && req_valid[cand]) begin
                    gvalid = 1'b1;
                    gidx   = cand;
                end
                cand = next_idx(cand);
            end
        end
    end

    assign req_ready = gvalid ? (3'b001 << gidx) : 3'b000;

    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (gidx)
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            2'd2: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    // Writes to $0 are accepted and latched but never enabled at the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= 2'd0;
            wr_en   <= 1'b0;
            wr_sel  <= 2'd0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (gvalid) begin
            ptr     <= next_idx(gidx);
            wr_sel  <= gidx;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
            wr_en   <= (sel_addr != '0);
        end else begin
            wr_en   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
// Directed scenarios plus randomized traffic against a round-robin reference model.
module tb_rf_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    req_valid;
    logic          stall;
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    logic [AW-1:0] req_addr0, req_addr1, req_addr2;
    logic [DW-1:0] req_data0, req_data1, req_data2;
    logic [2:0]    req_ready;
    logic [1:0]    wr_sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign req_addr0 = a[0];
    assign req_addr1 = a[1];
    assign req_addr2 = a[2];
    assign req_data0 = d[0];
    assign req_data1 = d[1];
    assign req_data2 = d[2];

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .req_ready(req_ready), .stall(stall), .wr_sel(wr_sel), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    int            mptr;
    logic [2:0]    exp_ready;
    logic          exp_en;
    logic [1:0]    exp_sel;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic [DW-1:0] rf_dut [32];

    always @(posedge clk) if (wr_en) rf_dut[wr_addr] <= wr_data;

    assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid[0] && !req_ready[0]) |=> (req_valid[0] && $stable(req_addr0) && $stable(req_data0)))
        else $error("FAIL protocol req0 withdrawn or changed before acceptance");
    assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid[1] && !req_ready[1]) |=> (req_valid[1] && $stable(req_addr1) && $stable(req_data1)))
        else $error("FAIL protocol req1 withdrawn or changed before acceptance");
    assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid[2] && !req_ready[2]) |=> (req_valid[2] && $stable(req_addr2) && $stable(req_data2)))
        else $error("FAIL protocol req2 withdrawn or changed before acceptance");

    function automatic int model_pick(input logic [2:0] v, input logic s, input int p);
        if (s) return -1;
        for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        mptr = 0; exp_en = 1'b0; exp_sel = 2'd0; exp_addr = '0; exp_data = '0;
    endtask

    // One clock: sample req_ready mid-cycle, predict, and return #1 after the edge.
    task automatic clk_cycle(output logic [2:0] obs);
        int g;
        @(negedge clk);
        obs = req_ready;
        g = rst_n ? model_pick(req_valid, stall, mptr) : -1;
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        @(posedge clk); #1;
        if (g >= 0) begin
            exp_sel = 2'(g); exp_addr = a[g]; exp_data = d[g];
            exp_en = (a[g] != '0); mptr = (g + 1) % 3;
        end else begin
            exp_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        logic [2:0] r;
        for (int n = 0; n < 12 && req_valid != 3'b000; n++) begin
            clk_cycle(r);
            req_valid = req_valid & ~r;
        end
        total_cnt++;
        if (req_valid !== 3'b000) $display("FAIL drain_timeout: valid=%b required 000", req_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [2:0] r;
        rst_n = 1'b1; stall = 1'b0; req_valid = 3'b111;
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if ({req_ready, wr_en, wr_sel, wr_addr, wr_data} !== '0)
            $display("FAIL reset_state: ready=%b en=%b sel=%b addr=%0d data=%h required all zero",
                     req_ready, wr_en, wr_sel, wr_addr, wr_data);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            clk_cycle(r);
            total_cnt++;
            if (r !== exp_ready) $display("FAIL reset_burst_ready: got %b required %b", r, exp_ready);
            else pass_cnt++;
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total_cnt++;
        if ({req_ready, wr_en, wr_sel, wr_addr, wr_data} !== '0)
            $display("FAIL reset_midburst: ready=%b en=%b sel=%b addr=%0d data=%h required all zero",
                     req_ready, wr_en, wr_sel, wr_addr, wr_data);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b001) $display("FAIL reset_first_grant: got %b required 001", r);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_single();
        logic [2:0] r;
        req_valid = 3'b010; a[1] = 5'd7; d[1] = 32'hDEADBEEF;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b010) $display("FAIL single_ready: got %b required 010", r);
        else pass_cnt++;
        total_cnt++;
        if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 2'b01, 5'd7, 32'hDEADBEEF})
            $display("FAIL single_write: en=%b sel=%b addr=%0d data=%h required 1/01/7/deadbeef",
                     wr_en, wr_sel, wr_addr, wr_data);
        else pass_cnt++;
        req_valid = 3'b000;
        clk_cycle(r);
        total_cnt++;
        if (wr_en !== 1'b0 || r !== 3'b000)
            $display("FAIL single_idle: en=%b ready=%b required 0/000", wr_en, r);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [2:0] r;
        do_reset();
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            clk_cycle(r);
            total_cnt++;
            if (r !== 3'(1 << (c % 3))) $display("FAIL rr_ready[%0d]: got %b required %b", c, r, 3'(1 << (c % 3)));
            else pass_cnt++;
            total_cnt++;
            if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 2'(c % 3), 5'(c % 3 + 1), d[c % 3]})
                $display("FAIL rr_write[%0d]: en=%b sel=%b addr=%0d data=%h required 1/%0d/%0d/%h",
                         c, wr_en, wr_sel, wr_addr, wr_data, c % 3, c % 3 + 1, d[c % 3]);
            else pass_cnt++;
        end
        drain();
    endtask

    task automatic test_stall();
        logic [2:0] r;
        do_reset();
        a[0] = 5'd4; a[2] = 5'd9; d[0] = 32'hA0A0; d[2] = 32'hC2C2;
        req_valid = 3'b101;
        clk_cycle(r);
        stall = 1'b1;
        total_cnt++;
        if (wr_en !== 1'b1 || wr_sel !== 2'b00) $display("FAIL stall_inflight: en=%b sel=%b required 1/00", wr_en, wr_sel);
        else pass_cnt++;
        repeat (3) begin
            clk_cycle(r);
            total_cnt++;
            if (r !== 3'b000 || wr_en !== 1'b0) $display("FAIL stall_block: ready=%b en=%b required 000/0", r, wr_en);
            else pass_cnt++;
        end
        stall = 1'b0;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b100 || {wr_en, wr_sel, wr_addr} !== {1'b1, 2'b10, 5'd9})
            $display("FAIL stall_resume: ready=%b en=%b sel=%b addr=%0d required 100/1/10/9", r, wr_en, wr_sel, wr_addr);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_zero_reg();
        logic [2:0] r;
        do_reset();
        a[0] = 5'd0; d[0] = 32'h1234;
        req_valid = 3'b001;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b001) $display("FAIL zero_ready: got %b required 001", r);
        else pass_cnt++;
        total_cnt++;
        if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b0, 2'b00, 5'd0, 32'h1234})
            $display("FAIL zero_write: en=%b sel=%b addr=%0d data=%h required 0/00/0/1234", wr_en, wr_sel, wr_addr, wr_data);
        else pass_cnt++;
        a[1] = 5'd5; d[1] = $urandom;
        req_valid = 3'b011;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b010) $display("FAIL zero_ptr_advance: got %b required 010", r);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_same_reg();
        logic [2:0] r;
        do_reset();
        a[0] = 5'd3; d[0] = 32'h3;
        req_valid = 3'b001;
        clk_cycle(r);
        req_valid = 3'b000;
        a[1] = 5'd31; a[2] = 5'd31; d[1] = 32'h1111_1111; d[2] = 32'h2222_2222;
        req_valid = 3'b110;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b010 || wr_sel !== 2'b01 || wr_data !== 32'h1111_1111)
            $display("FAIL samereg_first: ready=%b sel=%b data=%h required 010/01/11111111", r, wr_sel, wr_data);
        else pass_cnt++;
        req_valid = 3'b100;
        clk_cycle(r);
        total_cnt++;
        if (r !== 3'b100 || wr_sel !== 2'b10 || wr_data !== 32'h2222_2222)
            $display("FAIL samereg_second: ready=%b sel=%b data=%h required 100/10/22222222", r, wr_sel, wr_data);
        else pass_cnt++;
        req_valid = 3'b000;
        clk_cycle(r);
        total_cnt++;
        if (rf_dut[31] !== 32'h2222_2222) $display("FAIL samereg_rf31: got %h required 22222222", rf_dut[31]);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0] r;
        int wt [3];
        int bad_fair = 0;
        do_reset();
        for (int i = 0; i < 3; i++) wt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            clk_cycle(r);
            total_cnt++;
            if (r !== exp_ready) $display("FAIL rand_ready[%0d]: got %b required %b", c, r, exp_ready);
            else pass_cnt++;
            total_cnt++;
            if ({wr_en, wr_sel, wr_addr, wr_data} !== {exp_en, exp_sel, exp_addr, exp_data})
                $display("FAIL rand_write[%0d]: en=%b sel=%b addr=%0d data=%h required %b/%b/%0d/%h",
                         c, wr_en, wr_sel, wr_addr, wr_data, exp_en, exp_sel, exp_addr, exp_data);
            else pass_cnt++;
            for (int i = 0; i < 3; i++) begin
                if (req_valid[i] && r[i]) wt[i] = 0;
                else if (req_valid[i] && !stall) wt[i]++;
                if (wt[i] > 2) bad_fair++;
                if (req_valid[i] && r[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d[i] = $urandom;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    a[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    d[i] = $urandom;
                end
            end
        end
        total_cnt++;
        if (bad_fair != 0) $display("FAIL rand_fairness: %0d late grants required 0", bad_fair);
        else pass_cnt++;
        stall = 1'b0;
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_zero_reg();
        test_same_reg();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
